// File: rtl/gate_sweep_pkg.sv
// -----------------------------------------------------------------------------
// gate_sweep_pkg
// Shared definitions for the gate sweep sequencer:
//   - sweep_state_e : 3-bit FSM state encoding
//   - SETTLE_W      : width of the settle counter (settle time 0..15)
//   - minterms(n)   : number of input minterms for an n-input unit (2^n)
// -----------------------------------------------------------------------------
package gate_sweep_pkg;

  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } sweep_state_e;

  function automatic int minterms(input int n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// -----------------------------------------------------------------------------
// sweep_settle_cnt
// Loadable down-counter that times the settle interval between driving an
// operand and sampling the unit outputs.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset
//   load     : load load_val on the next edge (has priority over dec)
//   load_val : value to load (settle cycles)
//   dec      : decrement by one on the next edge (saturates at 0)
//   expire   : counter currently holds 1, i.e. this is the last settle cycle
// -----------------------------------------------------------------------------
module sweep_settle_cnt
  import gate_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                expire
);

  localparam logic [SETTLE_W-1:0] CNT_ZERO = {SETTLE_W{1'b0}};
  localparam logic [SETTLE_W-1:0] CNT_ONE  = SETTLE_W'(1'b1);

  logic [SETTLE_W-1:0] cnt_r;

  // Counter register: load wins over decrement, decrement stops at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expire on the value 1 so the FSM leaves SETTLE after exactly load_val cycles.
  assign expire = (cnt_r == CNT_ONE);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl
// Exhaustive sweep sequencer for a small combinational logic unit. On start it
// drives every minterm in ascending order, waits SETTLE cycles, samples the two
// unit outputs and builds their truth tables.
// Optional feature macro: GATE_SWEEP_CHECK_EN -- when defined, records the first
// minterm at which s_in and t_in disagree; otherwise mismatch outputs are 0.
// Parameters:
//   N      : number of unit inputs (M = 2^N minterms)
//   SETTLE : settle cycles between drive and sample, 0..15
// Ports:
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   start               : sweep request, sampled only in IDLE
//   busy                : sweep in progress (accept edge through last SAMPLE)
//   done                : one-cycle pulse after the last minterm
//   operand [N-1:0]     : unit inputs, equals the current minterm index
//   s_in, t_in          : unit outputs
//   tt_s, tt_t [M-1:0]  : captured truth tables, bit m = output at minterm m
//   mismatch            : s and t differed at some minterm
//   mismatch_idx[N-1:0] : first differing minterm
// -----------------------------------------------------------------------------
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [N-1:0]              operand,
  input  logic                      s_in,
  input  logic                      t_in,
  output logic [minterms(N)-1:0]    tt_s,
  output logic [minterms(N)-1:0]    tt_t,
  output logic                      mismatch,
  output logic [N-1:0]              mismatch_idx
);

  localparam int                  M          = minterms(N);
  localparam logic [N-1:0]        IDX_ZERO   = {N{1'b0}};
  localparam logic [N-1:0]        IDX_ONE    = N'(1'b1);
  localparam logic [N-1:0]        IDX_LAST   = {N{1'b1}};
  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE);
  localparam bit                  SETTLE_ZERO = (SETTLE == 0);

  sweep_state_e     state_r;
  sweep_state_e     state_s;
  logic [N-1:0]     idx_r;
  logic [M-1:0]     tt_s_r;
  logic [M-1:0]     tt_t_r;
  logic             busy_r;
  logic             done_r;
  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic             cnt_expire_s;
  logic             accept_s;
  logic             sample_s;

  assign accept_s = (state_r == ST_IDLE) && start;
  assign sample_s = (state_r == ST_SAMPLE);

  sweep_settle_cnt u_settle_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (SETTLE_VAL),
    .dec      (cnt_dec_s),
    .expire   (cnt_expire_s)
  );

  // Next-state and settle-counter control.
  always_comb begin
    state_s    = state_r;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_DRIVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        cnt_load_s = 1'b1;
        if (SETTLE_ZERO) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_dec_s = 1'b1;
        if (cnt_expire_s) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        if (idx_r == IDX_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Index, truth-table capture and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r  <= IDX_ZERO;
      tt_s_r <= {M{1'b0}};
      tt_t_r <= {M{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      // Flags are decoded from the next state so they line up with it.
      busy_r <= (state_s == ST_DRIVE) || (state_s == ST_SETTLE) ||
                (state_s == ST_SAMPLE);
      done_r <= (state_s == ST_DONE);
      if (accept_s) begin
        idx_r  <= IDX_ZERO;
        tt_s_r <= {M{1'b0}};
        tt_t_r <= {M{1'b0}};
      end else if (sample_s) begin
        tt_s_r[idx_r] <= s_in;
        tt_t_r[idx_r] <= t_in;
        // Holding at the last minterm keeps operand at M-1 after the sweep.
        if (idx_r != IDX_LAST) begin
          idx_r <= idx_r + IDX_ONE;
        end else begin
          idx_r <= idx_r;
        end
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // The index register drives the unit directly: it only changes on edges
  // that enter DRIVE, so operand is stable through settle and sample.
  assign operand = idx_r;
  assign tt_s    = tt_s_r;
  assign tt_t    = tt_t_r;
  assign busy    = busy_r;
  assign done    = done_r;

`ifdef GATE_SWEEP_CHECK_EN
  logic         mismatch_r;
  logic [N-1:0] mismatch_idx_r;

  // First-difference checker: once set, later differences are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_r     <= 1'b0;
      mismatch_idx_r <= IDX_ZERO;
    end else if (accept_s) begin
      mismatch_r     <= 1'b0;
      mismatch_idx_r <= IDX_ZERO;
    end else if (sample_s && (s_in != t_in) && !mismatch_r) begin
      mismatch_r     <= 1'b1;
      mismatch_idx_r <= idx_r;
    end else begin
      mismatch_r     <= mismatch_r;
      mismatch_idx_r <= mismatch_idx_r;
    end
  end

  assign mismatch     = mismatch_r;
  assign mismatch_idx = mismatch_idx_r;
`else
  assign mismatch     = 1'b0;
  assign mismatch_idx = IDX_ZERO;
`endif

endmodule
